// File: rtl/sc_pkg.sv
// sc_pkg -- shared types and constants for the stochastic stream stages.
//   sc_dec_state_t   : decoder FSM state encoding
//   SC_DEFAULT_CNT_W : default counter/window width, shared with the pulse and bit-stream stages
package sc_pkg;

   localparam int SC_DEFAULT_CNT_W = 16;

   typedef enum logic [1:0] {
      SC_IDLE  = 2'd0,
      SC_ACCUM = 2'd1,
      SC_DONE  = 2'd2
   } sc_dec_state_t;

endpackage

// File: rtl/sc_stream_decoder_if.sv
// sc_stream_decoder_if -- stream/measurement bundle between a stream decoder and its user.
//   bit_stream  : serial stream to decode
//   start       : request a new measurement window
//   window_len  : window length in cycles
//   busy        : decoder is measuring or presenting a result
//   valid       : one-cycle strobe, count_out/max_run hold a new result
//   count_out   : number of '1' samples in the last completed window
//   max_run     : longest run of '1's in the last completed window (zero when run tracking is off)
// Modports: master = stream source / result consumer, slave = decoder.
interface sc_stream_decoder_if
   import sc_pkg::*;
#(
   parameter int CNT_W = SC_DEFAULT_CNT_W
);

   logic             bit_stream;
   logic             start;
   logic [CNT_W-1:0] window_len;
   logic             busy;
   logic             valid;
   logic [CNT_W-1:0] count_out;
   logic [CNT_W-1:0] max_run;

   modport master (
      output bit_stream, start, window_len,
      input  busy, valid, count_out, max_run
   );

   modport slave (
      input  bit_stream, start, window_len,
      output busy, valid, count_out, max_run
   );

endinterface

// File: rtl/sc_run_tracker.sv
// sc_run_tracker -- tracks the current run of consecutive '1's and its maximum within a window.
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : window start, clears run and maximum
//   en            : sample bit_in this cycle
//   bit_in        : stream bit
//   run_max_nxt   : maximum including the bit sampled this cycle (value the max register loads)
// Only instantiated when SC_DEC_RUNLEN_EN is defined.
module sc_run_tracker
   import sc_pkg::*;
#(
   parameter int CNT_W = SC_DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [CNT_W-1:0] run_max_nxt
);

   logic [CNT_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic [CNT_W-1:0] run_inc;

   // a run can never exceed the window length, so the increment cannot wrap
   assign run_inc = run_q + CNT_W'(1);

   always_comb begin
      run_d = run_q;
      max_d = max_q;
      if (clr) begin
         run_d = '0;
         max_d = '0;
      end else if (en) begin
         if (bit_in) begin
            run_d = run_inc;
            if (run_inc > max_q) begin
               max_d = run_inc;
            end
         end else begin
            run_d = '0;
         end
      end
   end

   assign run_max_nxt = max_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q <= '0;
         max_q <= '0;
      end else begin
         run_q <= run_d;
         max_q <= max_d;
      end
   end

endmodule

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder -- counts '1' samples of a serial stream over an N-cycle window and reports
// the binary count with a one-cycle valid strobe.
//   clk, rst   : clock, asynchronous active-high reset
//   dec_if     : sc_stream_decoder_if.slave (bit_stream, start, window_len in;
//                busy, valid, count_out, max_run out)
// Build option: SC_DEC_RUNLEN_EN adds longest-run-of-ones tracking (max_run); otherwise max_run = 0.
//
// state    | meaning
// SC_IDLE  | waiting for start; start with window_len==0 goes straight to SC_DONE
// SC_ACCUM | sampling bit_stream, one sample per cycle, rem counts down to 1
// SC_DONE  | valid high for one cycle, result registers already loaded
module sc_stream_decoder
   import sc_pkg::*;
#(
   parameter int CNT_W = SC_DEFAULT_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   sc_stream_decoder_if.slave   dec_if
);

   sc_dec_state_t    state_q, state_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   // rem holds the latched window length and counts it down; window_len is not looked at again
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic win_start;
   logic win_zero;
   logic win_last;

   assign win_start = (state_q == SC_IDLE) && dec_if.start && (dec_if.window_len != '0);
   assign win_zero  = (state_q == SC_IDLE) && dec_if.start && (dec_if.window_len == '0);
   assign win_last  = (state_q == SC_ACCUM) && (rem_q == CNT_W'(1));

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      count_d = count_q;
      case (state_q)
         SC_IDLE: begin
            if (win_start) begin
               acc_d   = '0;
               rem_d   = dec_if.window_len;
               state_d = SC_ACCUM;
            end else if (win_zero) begin
               count_d = '0;
               state_d = SC_DONE;
            end
         end
         SC_ACCUM: begin
            acc_d = acc_q + CNT_W'(dec_if.bit_stream);
            rem_d = rem_q - CNT_W'(1);
            if (win_last) begin
               count_d = acc_q + CNT_W'(dec_if.bit_stream);
               state_d = SC_DONE;
            end
         end
         SC_DONE: begin
            state_d = SC_IDLE;
         end
         default: begin
            state_d = SC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SC_IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         count_q <= count_d;
      end
   end

   assign dec_if.busy      = (state_q == SC_ACCUM) || (state_q == SC_DONE);
   assign dec_if.valid     = (state_q == SC_DONE);
   assign dec_if.count_out = count_q;

`ifdef SC_DEC_RUNLEN_EN
   logic [CNT_W-1:0] run_max_nxt;
   logic [CNT_W-1:0] max_run_q, max_run_d;

   sc_run_tracker #(
      .CNT_W (CNT_W)
   ) u_run_tracker (
      .clk         (clk),
      .rst         (rst),
      .clr         (win_start),
      .en          (state_q == SC_ACCUM),
      .bit_in      (dec_if.bit_stream),
      .run_max_nxt (run_max_nxt)
   );

   // loaded on the same edge as count_out so both describe the same window
   always_comb begin
      max_run_d = max_run_q;
      if (win_zero) begin
         max_run_d = '0;
      end else if (win_last) begin
         max_run_d = run_max_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_run_q <= '0;
      end else begin
         max_run_q <= max_run_d;
      end
   end

   assign dec_if.max_run = max_run_q;
`else
   assign dec_if.max_run = '0;
`endif

endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder -- self-checking bench for sc_stream_decoder.
// Expected count and longest run are computed from the stimulus bit list; timing expectations
// follow from "start accepted on edge k, samples on edges k+1..k+N, valid after edge k+N".
module tb_sc_stream_decoder;
   import sc_pkg::*;

   localparam int CNT_W = SC_DEFAULT_CNT_W;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sc_stream_decoder_if #(.CNT_W(CNT_W)) dif ();

   sc_stream_decoder #(.CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .dec_if (dif)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int exp_count = 0;
   int exp_max = 0;
   bit bits_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_count();
      int s = 0;
      foreach (bits_q[i]) s += int'(bits_q[i]);
      return s;
   endfunction

   function automatic int ref_max_run();
      int cur = 0;
      int best = 0;
      foreach (bits_q[i]) begin
         cur = bits_q[i] ? cur + 1 : 0;
         if (cur > best) best = cur;
      end
      return best;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outputs(input string tag, input int e_busy, input int e_valid);
      chk({tag, ".busy"},  32'(dif.busy),      e_busy);
      chk({tag, ".valid"}, 32'(dif.valid),     e_valid);
      chk({tag, ".count"}, 32'(dif.count_out), exp_count);
      chk({tag, ".max"},   32'(dif.max_run),   exp_max);
   endtask

   // Called #1 after an edge with the decoder idle; bits_q must hold len entries.
   // repulse_at: sample index at which start is pulsed again (-1 = never)
   // rst_at:     sample index at which reset is pulsed (-1 = never)
   task automatic run_window(input string tag, input int len, input int repulse_at,
                             input bit repulse_done, input int rst_at);
      chk({tag, ".idle_busy"}, 32'(dif.busy), 0);
      dif.window_len = CNT_W'(len);
      dif.start      = 1'b1;
      dif.bit_stream = 1'($urandom);
      step();
      dif.start = 1'b0;
      for (int i = 0; i < len; i++) begin
         dif.bit_stream = bits_q[i];
         dif.start      = (i == repulse_at);
         dif.window_len = CNT_W'($urandom);
         if (i == rst_at) begin
            rst = 1'b1;
            #1;
            exp_count = 0;
            exp_max   = 0;
            chk_outputs({tag, ".in_rst"}, 0, 0);
            #1;
            rst = 1'b0;
            dif.start = 1'b0;
            step();
            chk_outputs({tag, ".after_rst"}, 0, 0);
            step();
            chk_outputs({tag, ".after_rst2"}, 0, 0);
            return;
         end
         chk({tag, ".acc_busy"},  32'(dif.busy),      1);
         chk({tag, ".acc_valid"}, 32'(dif.valid),     0);
         chk({tag, ".acc_hold"},  32'(dif.count_out), exp_count);
         step();
      end
      dif.start      = repulse_done;
      dif.bit_stream = 1'($urandom);
      exp_count = ref_count();
`ifdef SC_DEC_RUNLEN_EN
      exp_max = ref_max_run();
`else
      exp_max = 0;
`endif
      chk_outputs({tag, ".done"}, 1, 1);
      step();
      dif.start = 1'b0;
      chk_outputs({tag, ".post"}, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len;
      dif.start      = 1'b0;
      dif.bit_stream = 1'b0;
      dif.window_len = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs("reset", 0, 0);
      rst = 1'b0;

      // idle after reset with a wiggling stream
      for (int c = 0; c < 20; c++) begin
         dif.bit_stream = 1'($urandom);
         dif.window_len = CNT_W'($urandom);
         step();
         chk_outputs("idle", 0, 0);
      end

      bits_q = '{1, 0, 1, 1, 0, 1, 1, 1};
      run_window("pat8", 8, -1, 1'b0, -1);
      chk("pat8.count6", 32'(dif.count_out), 6);

      bits_q = {};
      repeat (100) bits_q.push_back(1'b1);
      run_window("ones100", 100, -1, 1'b0, -1);
      chk("ones100.count", 32'(dif.count_out), 100);

      bits_q = {};
      run_window("len0", 0, -1, 1'b0, -1);

      bits_q = {};
      repeat (10) bits_q.push_back(1'($urandom));
      run_window("repulse", 10, 4, 1'b1, -1);

      bits_q = {};
      repeat (16) bits_q.push_back(1'b1);
      run_window("rst_mid", 16, -1, 1'b0, 9);
      run_window("after_rst", 16, -1, 1'b0, -1);

      bits_q = '{1};
      run_window("len1", 1, -1, 1'b1, -1);

      for (int w = 0; w < 40; w++) begin
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 40);
         bits_q = {};
         for (int i = 0; i < len; i++) bits_q.push_back(1'($urandom));
         run_window("rand", len,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : -1,
                    1'($urandom), -1);
         repeat ($urandom_range(0, 3)) begin
            dif.bit_stream = 1'($urandom);
            step();
            chk_outputs("gap", 0, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
